// File: rtl/reset_sequencer.sv
// Staged reset release: memories first, then core, then ready.
// Also runs soft core resets through a level req / pulse ack handshake.
module reset_sequencer #(
  parameter int HOLD_CYCLES       = 16,
  parameter int STAGE_DELAY       = 8,
  parameter int SOFT_PULSE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_locked,
  input  logic soft_reset_req,
  output logic soft_reset_ack,
  output logic reset_mem,
  output logic reset_core,
  output logic ready
);

  localparam int MAX_AB =
    (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
  localparam int MAX_ALL =
    (MAX_AB > SOFT_PULSE_CYCLES) ? MAX_AB : SOFT_PULSE_CYCLES;
  localparam int CW = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] SOFT_LAST  = CW'(SOFT_PULSE_CYCLES - 1);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end
  if (STAGE_DELAY < 1) begin : g_bad_stage
    $error("STAGE_DELAY must be >= 1");
  end
  if (SOFT_PULSE_CYCLES < 1) begin : g_bad_soft
    $error("SOFT_PULSE_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    HOLD,
    MEM_UP,
    RUN,
    SOFT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          armed;
  logic          soft_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= HOLD;
      cnt            <= '0;
      reset_mem      <= 1'b1;
      reset_core     <= 1'b1;
      ready          <= 1'b0;
      soft_reset_ack <= 1'b0;
      soft_done      <= 1'b0;
      armed          <= 1'b1;
    end else begin
      soft_reset_ack <= 1'b0;
      if (!soft_reset_req) armed <= 1'b1;
      // lock loss outside HOLD restarts the whole sequence
      if (!clk_locked && state != HOLD) begin
        state      <= HOLD;
        cnt        <= '0;
        reset_mem  <= 1'b1;
        reset_core <= 1'b1;
        ready      <= 1'b0;
        soft_done  <= 1'b0;
      end else begin
        unique case (state)
          HOLD: begin
            if (!clk_locked) begin
              cnt <= '0;
            end else if (cnt == HOLD_LAST) begin
              reset_mem <= 1'b0;
              cnt       <= '0;
              state     <= MEM_UP;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          MEM_UP: begin
            if (cnt == STAGE_LAST) begin
              reset_core <= 1'b0;
              cnt        <= '0;
              state      <= RUN;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          RUN: begin
            soft_reset_ack <= soft_done;
            soft_done      <= 1'b0;
            if (soft_reset_req && armed) begin
              reset_core <= 1'b1;
              ready      <= 1'b0;
              armed      <= 1'b0;
              cnt        <= '0;
              state      <= SOFT;
            end else begin
              ready <= 1'b1;
            end
          end
          SOFT: begin
            if (cnt == SOFT_LAST) begin
              reset_core <= 1'b0;
              soft_done  <= 1'b1;
              cnt        <= '0;
              state      <= RUN;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= HOLD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed plus random stimulus against a count-based reference model
// of the reset release timeline and soft reset handshake.
module tb_reset_sequencer;

  localparam int H = 16;
  localparam int S = 8;
  localparam int P = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk_locked = 1'b1;
  logic soft_reset_req = 1'b0;
  logic soft_reset_ack;
  logic reset_mem;
  logic reset_core;
  logic ready;

  reset_sequencer #(
    .HOLD_CYCLES(H),
    .STAGE_DELAY(S),
    .SOFT_PULSE_CYCLES(P)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk_locked(clk_locked),
    .soft_reset_req(soft_reset_req),
    .soft_reset_ack(soft_reset_ack),
    .reset_mem(reset_mem),
    .reset_core(reset_core),
    .ready(ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ack_count = 0;

  // model: up = consecutive locked edges since restart (saturating),
  // sl = edges left until a soft reset releases the core
  int up = 0;
  int sl = 0;
  bit done = 1'b0;
  bit armed = 1'b1;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic q);
    bit run_before, trig;
    logic e_mem, e_core, e_ready, e_ack;
    @(negedge clk);
    reset = r;
    clk_locked = l;
    soft_reset_req = q;
    @(posedge clk);
    #1;
    e_ready = 1'b0;
    e_ack = 1'b0;
    if (r) begin
      up = 0; sl = 0; done = 1'b0; armed = 1'b1;
    end else if (!l) begin
      up = 0; sl = 0; done = 1'b0;
      if (!q) armed = 1'b1;
    end else begin
      run_before = (up >= H + S) && (sl == 0);
      trig = run_before && q && armed;
      e_ack = run_before && done;
      if (run_before) done = 1'b0;
      e_ready = run_before && !trig;
      if (trig) begin
        sl = P;
        armed = 1'b0;
      end else if (sl > 0) begin
        sl--;
        if (sl == 0) done = 1'b1;
      end
      if (!q) armed = 1'b1;
      if (up < H + S) up++;
    end
    e_mem = (up < H);
    e_core = (up < H + S) || (sl > 0);
    chk("reset_mem", reset_mem, e_mem);
    chk("reset_core", reset_core, e_core);
    chk("ready", ready, e_ready);
    chk("soft_reset_ack", soft_reset_ack, e_ack);
    chk("inv_mem_core", reset_mem & ~reset_core, 1'b0);
    chk("inv_ready", ready & (reset_mem | reset_core), 1'b0);
    if (soft_reset_ack === 1'b1) ack_count++;
  endtask

  task automatic steps(input int n, input logic r, input logic l,
                       input logic q);
    for (int i = 0; i < n; i++) step(r, l, q);
  endtask

  int first_mem_low;
  bit lock_state;
  bit req_state;

  initial begin
    // test 1: power-on reset then default release timing
    steps(5, 1, 1, 0);
    first_mem_low = 0;
    for (int i = 1; i <= 30; i++) begin
      step(0, 1, 0);
      if (first_mem_low == 0 && reset_mem === 1'b0) first_mem_low = i;
    end
    chk_int("mem_release_edge", first_mem_low, H);

    // test 2: late lock, then a lock glitch inside HOLD
    steps(2, 1, 1, 0);
    steps(10, 0, 0, 0);
    steps(8, 0, 1, 0);
    step(0, 0, 0);
    steps(30, 0, 1, 0);

    // test 3: held req gives exactly one ack; re-arm gives a second
    ack_count = 0;
    steps(20, 0, 1, 1);
    chk_int("ack_count_held", ack_count, 1);
    steps(2, 0, 1, 0);
    steps(10, 0, 1, 1);
    chk_int("ack_count_rearm", ack_count, 2);
    steps(2, 0, 1, 0);

    // test 4: req during MEM_UP is ignored
    ack_count = 0;
    steps(3, 1, 1, 0);
    steps(18, 0, 1, 0);
    steps(4, 0, 1, 1);
    steps(10, 0, 1, 0);
    chk_int("ack_count_memup", ack_count, 0);

    // test 5: lock loss in RUN and in SOFT
    step(0, 0, 0);
    steps(30, 0, 1, 0);
    ack_count = 0;
    steps(2, 0, 1, 1);
    step(0, 0, 1);
    step(0, 1, 0);
    steps(30, 0, 1, 0);
    chk_int("ack_count_lockloss", ack_count, 0);

    // test 6: reset together with lock loss and req mid-SOFT
    steps(2, 0, 1, 1);
    step(1, 0, 1);
    steps(30, 0, 1, 0);

    // random phase
    lock_state = 1'b1;
    req_state = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (lock_state) begin
        if ($urandom_range(0, 149) == 0) lock_state = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        lock_state = 1'b1;
      end
      if ($urandom_range(0, 11) == 0) req_state = ~req_state;
      step(($urandom_range(0, 299) == 0), lock_state, req_state);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
